// File: rtl/gfx_line.sv
// rtl/gfx_line.sv - Bresenham line rasterizer feeding the gfx pixel write port
// Accepts one line command, then streams every pixel from endpoint 0 to endpoint 1.
module gfx_line #(
   parameter int FB_X_BITS  = 10,
   parameter int FB_Y_BITS  = 10,
   parameter int PIXEL_BITS = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [FB_X_BITS-1:0]  cmd_x0,
   input  logic [FB_X_BITS-1:0]  cmd_x1,
   input  logic [FB_Y_BITS-1:0]  cmd_y0,
   input  logic [FB_Y_BITS-1:0]  cmd_y1,
   input  logic [PIXEL_BITS-1:0] cmd_color,
   output logic                  gfx_valid,
   input  logic                  gfx_ready,
   output logic [FB_X_BITS-1:0]  gfx_x,
   output logic [FB_Y_BITS-1:0]  gfx_y,
   output logic [PIXEL_BITS-1:0] gfx_color,
   output logic                  busy,
   output logic                  done
);

   localparam int N = (FB_X_BITS > FB_Y_BITS) ? FB_X_BITS : FB_Y_BITS;
   localparam int W = N + 2;
   localparam logic [FB_X_BITS-1:0] X_ONE = {{(FB_X_BITS-1){1'b0}}, 1'b1};
   localparam logic [FB_Y_BITS-1:0] Y_ONE = {{(FB_Y_BITS-1){1'b0}}, 1'b1};

   typedef enum logic {S_IDLE, S_DRAW} state_t;

   state_t                 r_state;
   logic [FB_X_BITS-1:0]   r_x;
   logic [FB_X_BITS-1:0]   r_x1;
   logic [FB_Y_BITS-1:0]   r_y;
   logic [FB_Y_BITS-1:0]   r_y1;
   logic [PIXEL_BITS-1:0]  r_color;
   logic signed [W-1:0]    r_dx;
   logic signed [W-1:0]    r_dy;
   logic signed [W-1:0]    r_err;
   logic                   r_sx_neg;
   logic                   r_sy_neg;
   logic                   r_valid;
   logic                   r_done;

   logic                   w_x_lt;
   logic                   w_y_lt;
   logic [FB_X_BITS-1:0]   w_adx;
   logic [FB_Y_BITS-1:0]   w_ady;
   logic signed [W-1:0]    w_dx_new;
   logic signed [W-1:0]    w_ady_ext;
   logic signed [W-1:0]    w_dy_new;
   logic signed [W-1:0]    w_err_new;
   logic signed [W:0]      w_e2;
   logic signed [W:0]      w_dx_ext;
   logic signed [W:0]      w_dy_ext;
   logic                   w_step_x;
   logic                   w_step_y;
   logic signed [W-1:0]    w_add_x;
   logic signed [W-1:0]    w_add_y;
   logic signed [W-1:0]    w_err_next;
   logic                   w_last;
   logic                   w_xfer;

   // Magnitudes are taken in the unsigned coordinate domain, then zero-extended.
   assign w_x_lt    = cmd_x0 < cmd_x1;
   assign w_y_lt    = cmd_y0 < cmd_y1;
   assign w_adx     = w_x_lt ? (cmd_x1 - cmd_x0) : (cmd_x0 - cmd_x1);
   assign w_ady     = w_y_lt ? (cmd_y1 - cmd_y0) : (cmd_y0 - cmd_y1);
   assign w_dx_new  = $signed({{(W-FB_X_BITS){1'b0}}, w_adx});
   assign w_ady_ext = $signed({{(W-FB_Y_BITS){1'b0}}, w_ady});
   assign w_dy_new  = -w_ady_ext;
   assign w_err_new = w_dx_new + w_dy_new;

   assign w_e2     = $signed({r_err, 1'b0});
   assign w_dx_ext = $signed({r_dx[W-1], r_dx});
   assign w_dy_ext = $signed({r_dy[W-1], r_dy});
   assign w_step_x = w_e2 >= w_dy_ext;
   assign w_step_y = w_e2 <= w_dx_ext;
   assign w_add_x  = w_step_x ? r_dy : '0;
   assign w_add_y  = w_step_y ? r_dx : '0;
   assign w_err_next = r_err + w_add_x + w_add_y;

   assign w_last = (r_x == r_x1) && (r_y == r_y1);
   assign w_xfer = r_valid && gfx_ready;

   assign cmd_ready = (r_state == S_IDLE) && !reset;
   assign busy      = (r_state == S_DRAW);
   assign gfx_valid = r_valid;
   assign gfx_x     = r_x;
   assign gfx_y     = r_y;
   assign gfx_color = r_color;
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_color  <= '0;
         r_dx     <= '0;
         r_dy     <= '0;
         r_err    <= '0;
         r_sx_neg <= 1'b0;
         r_sy_neg <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_x      <= cmd_x0;
                  r_y      <= cmd_y0;
                  r_x1     <= cmd_x1;
                  r_y1     <= cmd_y1;
                  r_color  <= cmd_color;
                  r_dx     <= w_dx_new;
                  r_dy     <= w_dy_new;
                  r_err    <= w_err_new;
                  r_sx_neg <= !w_x_lt;
                  r_sy_neg <= !w_y_lt;
                  r_valid  <= 1'b1;
                  r_state  <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     if (w_step_x) r_x <= r_sx_neg ? (r_x - X_ONE) : (r_x + X_ONE);
                     if (w_step_y) r_y <= r_sy_neg ? (r_y - Y_ONE) : (r_y + Y_ONE);
                     r_err <= w_err_next;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gfx_line.sv
// tb/tb_gfx_line.sv - directed bench for gfx_line at default and narrow widths
// The narrow instance (4-bit x, 3-bit y) exercises full-range coordinates.
module tb_gfx_line;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        cmd_valid_b, cmd_valid_s;
   logic [9:0]  cmd_x0, cmd_x1, cmd_y0, cmd_y1;
   logic [11:0] cmd_color;
   logic        gfx_ready;

   logic        cmd_ready_b, gfx_valid_b, busy_b, done_b;
   logic [9:0]  gfx_x_b, gfx_y_b;
   logic [11:0] gfx_color_b;

   logic        cmd_ready_s, gfx_valid_s, busy_s, done_s;
   logic [3:0]  gfx_x_s;
   logic [2:0]  gfx_y_s;
   logic [11:0] gfx_color_s;

   int          n_pass = 0;
   int          n_checks = 0;
   bit          sel = 1'b0;
   int          ex[$];
   int          ey[$];

   logic        obs_cmd_ready, obs_valid, obs_busy, obs_done;
   logic [9:0]  obs_x, obs_y;
   logic [11:0] obs_color;

   assign obs_cmd_ready = sel ? cmd_ready_s : cmd_ready_b;
   assign obs_valid     = sel ? gfx_valid_s : gfx_valid_b;
   assign obs_busy      = sel ? busy_s      : busy_b;
   assign obs_done      = sel ? done_s      : done_b;
   assign obs_x         = sel ? {6'b0, gfx_x_s} : gfx_x_b;
   assign obs_y         = sel ? {7'b0, gfx_y_s} : gfx_y_b;
   assign obs_color     = sel ? gfx_color_s : gfx_color_b;

   gfx_line u_dut_b (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_color(cmd_color),
      .gfx_valid(gfx_valid_b), .gfx_ready(gfx_ready),
      .gfx_x(gfx_x_b), .gfx_y(gfx_y_b), .gfx_color(gfx_color_b),
      .busy(busy_b), .done(done_b)
   );

   gfx_line #(.FB_X_BITS(4), .FB_Y_BITS(3), .PIXEL_BITS(12)) u_dut_s (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
      .cmd_x0(cmd_x0[3:0]), .cmd_x1(cmd_x1[3:0]), .cmd_y0(cmd_y0[2:0]), .cmd_y1(cmd_y1[2:0]),
      .cmd_color(cmd_color),
      .gfx_valid(gfx_valid_s), .gfx_ready(gfx_ready),
      .gfx_x(gfx_x_s), .gfx_y(gfx_y_s), .gfx_color(gfx_color_s),
      .busy(busy_s), .done(done_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Entered and left at posedge+1; expected pixels come from ex/ey.
   task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [11:0] col, input bit bp);
      int k;
      int cyc;
      logic rdy;
      cmd_x0 = 10'(x0);
      cmd_y0 = 10'(y0);
      cmd_x1 = 10'(x1);
      cmd_y1 = 10'(y1);
      cmd_color = col;
      if (sel) cmd_valid_s = 1'b1;
      else     cmd_valid_b = 1'b1;
      chk("cmd_ready_idle", obs_cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid_b = 1'b0;
      cmd_valid_s = 1'b0;
      chk("busy_start", obs_busy, 1);
      k = 0;
      cyc = 0;
      while (k < ex.size() && cyc < 200) begin
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         gfx_ready = rdy;
         chk("pix_valid", obs_valid, 1);
         chk("pix_x", obs_x, ex[k]);
         chk("pix_y", obs_y, ey[k]);
         chk("pix_color", obs_color, col);
         chk("done_low", obs_done, 0);
         @(posedge clk); #1;
         cyc++;
         if (rdy) k++;
      end
      chk("pixel_count", k, ex.size());
      if (!bp) chk("cycle_count", cyc, ex.size());
      chk("valid_end", obs_valid, 0);
      chk("done_pulse", obs_done, 1);
      chk("busy_end", obs_busy, 0);
      chk("cmd_ready_end", obs_cmd_ready, 1);
      @(posedge clk); #1;
      chk("done_clear", obs_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cmd_valid_b = 1'b0;
      cmd_valid_s = 1'b0;
      cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0;
      cmd_color = '0;
      gfx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", gfx_valid_b, 0);
      chk("rst_done", done_b, 0);
      chk("rst_busy", busy_b, 0);
      chk("rst_cmd_ready", cmd_ready_b, 0);
      chk("rst_x", gfx_x_b, 0);
      chk("rst_y", gfx_y_b, 0);
      chk("rst_color", gfx_color_b, 0);
      chk("rst_valid_s", gfx_valid_s, 0);
      chk("rst_cmd_ready_s", cmd_ready_s, 0);
      reset = 1'b0;
      #1;
      chk("cmd_ready_after_rst", cmd_ready_b, 1);
      @(posedge clk); #1;

      ex = '{0, 1, 2, 3}; ey = '{0, 0, 0, 0};
      run_line(0, 0, 3, 0, 12'hABC, 1'b0);

      ex = '{1, 1, 1, 2, 2, 2}; ey = '{0, 1, 2, 3, 4, 5};
      run_line(1, 0, 2, 5, 12'h123, 1'b0);

      ex = '{5, 4, 3, 2}; ey = '{5, 4, 3, 2};
      run_line(5, 5, 2, 2, 12'h456, 1'b0);

      ex = '{7}; ey = '{3};
      run_line(7, 3, 7, 3, 12'h789, 1'b0);

      ex = '{0, 1, 2, 3}; ey = '{0, 0, 1, 1};
      run_line(0, 0, 3, 1, 12'hF0F, 1'b0);
      run_line(0, 0, 3, 1, 12'hF0F, 1'b1);
      run_line(0, 0, 3, 1, 12'h0F0, 1'b1);

      sel = 1'b1;
      ex.delete(); ey.delete();
      for (int k = 0; k < 16; k++) begin ex.push_back(15 - k); ey.push_back(7 - k / 2); end
      run_line(15, 7, 0, 0, 12'h111, 1'b0);
      ex.delete(); ey.delete();
      for (int k = 0; k < 16; k++) begin ex.push_back(k); ey.push_back(7 - k / 2); end
      run_line(0, 7, 15, 0, 12'h222, 1'b0);
      ex.delete(); ey.delete();
      for (int k = 0; k < 16; k++) begin ex.push_back(15 - k); ey.push_back(k / 2); end
      run_line(15, 0, 0, 7, 12'h333, 1'b1);
      sel = 1'b0;

      cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_x1 = 10'd9; cmd_y1 = 10'd0;
      cmd_color = 12'h555;
      cmd_valid_b = 1'b1;
      @(posedge clk); #1;
      cmd_valid_b = 1'b0;
      gfx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_x", gfx_x_b, 2);
      reset = 1'b1;
      gfx_ready = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_valid", gfx_valid_b, 0);
      chk("mid_rst_busy", busy_b, 0);
      chk("mid_rst_done", done_b, 0);
      chk("mid_rst_cmd_ready", cmd_ready_b, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_valid", gfx_valid_b, 0);
      chk("post_rst_cmd_ready", cmd_ready_b, 1);
      chk("post_rst_done", done_b, 0);
      chk("post_rst_busy", busy_b, 0);

      ex = '{2, 3, 4}; ey = '{2, 2, 2};
      run_line(2, 2, 4, 2, 12'hCDE, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
